// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

    // Width of architectural register indices
    localparam int unsigned REG_W = 5;

    // Memory-wait tracking FSM
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    // EX operand source encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Winning hazard condition for the current cycle, highest priority first
    typedef enum logic [2:0] {
        ACT_NONE     = 3'd0,
        ACT_ERROR    = 3'd1,
        ACT_MWAIT    = 3'd2,
        ACT_BRANCH   = 3'd3,
        ACT_LOAD_USE = 3'd4
    } action_t;

    // True when a later stage writes a non-zero register the EX operand reads
    function automatic logic rd_matches(
        input logic             reg_write,
        input logic [REG_W-1:0] rd_addr,
        input logic [REG_W-1:0] rs_addr
    );
        return reg_write && (rd_addr != '0) && (rd_addr == rs_addr);
    endfunction

endpackage

// File: rtl/hazard_control_unit_fwd_select.sv
// Forwarding source select for one EX operand.
// MEM result is younger than WB, so it takes precedence.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs_addr,
    input  logic [REG_W-1:0] mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd_addr,
    input  logic             wb_reg_write,
    output logic [1:0]       fwd_sel
);

    // Pick the youngest in-flight producer of the operand, else the regfile
    always_comb begin
        fwd_sel = FWD_RF;
        if (rd_matches(mem_reg_write, mem_rd_addr, ex_rs_addr)) begin
            fwd_sel = FWD_MEM;
        end else if (rd_matches(wb_reg_write, wb_rd_addr, ex_rs_addr)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: stall/flush for IF/ID, ID/EX, EX/MEM, MEM/WB,
// PC hold, EX forwarding selects, and data-memory wait/timeout tracking.
// Optional macro HAZARD_PERF_EN adds saturating performance counters for
// load-use stalls, memory-wait stall cycles and branch flushes.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1_addr,
    input  logic [REG_W-1:0] id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rs1_addr,
    input  logic [REG_W-1:0] ex_rs2_addr,
    input  logic [REG_W-1:0] ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd_addr,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             flush_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_mem_wb,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] perf_load_use_cnt,
    output logic [CNT_W-1:0] perf_mem_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic             mem_timeout
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              mwait;
    logic              load_use;
    action_t           action;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    fwd_select u_fwd_a (
        .ex_rs_addr    (ex_rs1_addr),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (fwd_a_raw)
    );

    fwd_select u_fwd_b (
        .ex_rs_addr    (ex_rs2_addr),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (fwd_b_raw)
    );

    // Forwarding selects are combinational but held at the regfile source in reset
    always_comb begin
        fwd_a_sel = rst_n ? fwd_a_raw : FWD_RF;
        fwd_b_sel = rst_n ? fwd_b_raw : FWD_RF;
    end

    // Raw hazard conditions
    always_comb begin
        mwait = ((state == RUN) && dmem_req && !dmem_ready) ||
                ((state == MEM_WAIT) && !dmem_ready);
        load_use = ex_mem_read && (ex_rd_addr != '0) &&
                   ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                    (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
    end

    // Resolve which hazard wins this cycle; reset forces no action
    always_comb begin
        action = ACT_NONE;
        if (!rst_n) begin
            action = ACT_NONE;
        end else if (state == ERROR) begin
            action = ACT_ERROR;
        end else if (mwait) begin
            action = ACT_MWAIT;
        end else if (ex_branch_taken) begin
            action = ACT_BRANCH;
        end else if (load_use) begin
            action = ACT_LOAD_USE;
        end
    end

    // Decode the winning hazard into pipeline-register controls
    always_comb begin
        pc_stall     = 1'b0;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_mem_wb = 1'b0;
        case (action)
            ACT_ERROR: begin
                pc_stall     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                stall_mem_wb = 1'b1;
            end
            ACT_MWAIT: begin
                // Freeze everything up to EX/MEM and feed a bubble into WB
                pc_stall     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end
            ACT_BRANCH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            ACT_LOAD_USE: begin
                pc_stall    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory-wait FSM with timeout counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCNT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCNT_LAST) begin
                        state       <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_ONE;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters of cycles in which each hazard was the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_use_cnt  <= '0;
            perf_mem_stall_cnt <= '0;
            perf_flush_cnt     <= '0;
        end else begin
            if ((action == ACT_LOAD_USE) && (perf_load_use_cnt != '1)) begin
                perf_load_use_cnt <= perf_load_use_cnt + 1'b1;
            end
            if ((action == ACT_MWAIT) && (perf_mem_stall_cnt != '1)) begin
                perf_mem_stall_cnt <= perf_mem_stall_cnt + 1'b1;
            end
            if ((action == ACT_BRANCH) && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit.
// Build with +define+HAZARD_PERF_EN to also exercise the performance counters.
module tb_hazard_control_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic       ex_mem_read, ex_branch_taken;
    logic [4:0] mem_rd_addr, wb_rd_addr;
    logic       mem_reg_write, wb_reg_write;
    logic       dmem_req, dmem_ready;
    logic       pc_stall, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
    logic       stall_ex_mem, flush_ex_mem, stall_mem_wb, flush_mem_wb;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_use_cnt, perf_mem_stall_cnt, perf_flush_cnt;
`endif

    // Control vector order: pc, s_ifid, f_ifid, s_idex, f_idex, s_exmem, f_exmem, s_memwb, f_memwb
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_LU   = 9'b110010000;
    localparam logic [8:0] C_BR   = 9'b001010000;
    localparam logic [8:0] C_MW   = 9'b110101001;
    localparam logic [8:0] C_ER   = 9'b110101010;

    logic [8:0] ctrl;
    assign ctrl = {pc_stall, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
                   stall_ex_mem, flush_ex_mem, stall_mem_wb, flush_mem_wb};

    int n_checks = 0;
    int n_errors = 0;

    hazard_control_unit #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rs1_addr     (ex_rs1_addr),
        .ex_rs2_addr     (ex_rs2_addr),
        .ex_rd_addr      (ex_rd_addr),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd_addr     (mem_rd_addr),
        .mem_reg_write   (mem_reg_write),
        .wb_rd_addr      (wb_rd_addr),
        .wb_reg_write    (wb_reg_write),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_stall        (pc_stall),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .stall_id_ex     (stall_id_ex),
        .flush_id_ex     (flush_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .flush_ex_mem    (flush_ex_mem),
        .stall_mem_wb    (stall_mem_wb),
        .flush_mem_wb    (flush_mem_wb),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
`ifdef HAZARD_PERF_EN
        .perf_load_use_cnt  (perf_load_use_cnt),
        .perf_mem_stall_cnt (perf_mem_stall_cnt),
        .perf_flush_cnt     (perf_flush_cnt),
`endif
        .mem_timeout     (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1_addr = '0; ex_rs2_addr = '0; ex_rd_addr = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_rd_addr = '0; mem_reg_write = 1'b0; wb_rd_addr = '0; wb_reg_write = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Forwarding match present during reset must not leak to the outputs
        mem_rd_addr = 5'd3; mem_reg_write = 1'b1; ex_rs1_addr = 5'd3;
        dmem_req = 1'b1;
        #2;
        check("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        check("reset_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        clear_inputs();
        #1 rst_n = 1'b1;
        step();

        // Forwarding priorities
        mem_rd_addr = 5'd3; wb_rd_addr = 5'd3; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        ex_rs1_addr = 5'd3; ex_rs2_addr = 5'd3;
        #1;
        check("fwd_a_mem", 32'(fwd_a_sel), 32'd2);
        check("fwd_b_mem", 32'(fwd_b_sel), 32'd2);
        check("fwd_no_ctrl", 32'(ctrl), 32'(C_NONE));
        mem_reg_write = 1'b0;
        #1 check("fwd_a_wb", 32'(fwd_a_sel), 32'd1);
        wb_rd_addr = 5'd0; ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0;
        #1 check("fwd_a_rd0", 32'(fwd_a_sel), 32'd0);
        ex_rs1_addr = 5'd7; ex_rs2_addr = 5'd9; wb_rd_addr = 5'd9;
        mem_rd_addr = 5'd7; mem_reg_write = 1'b1;
        #1;
        check("fwd_a_mem7", 32'(fwd_a_sel), 32'd2);
        check("fwd_b_wb9", 32'(fwd_b_sel), 32'd1);
        clear_inputs();

        // Load-use: one bubble, then clean once the load has moved on
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
        #1 check("lu_rs1", 32'(ctrl), 32'(C_LU));
        id_uses_rs1 = 1'b0;
        #1 check("lu_not_used", 32'(ctrl), 32'(C_NONE));
        id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5; id_rs1_addr = 5'd0;
        #1 check("lu_rs2", 32'(ctrl), 32'(C_LU));
        ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
        #1 check("lu_rd0", 32'(ctrl), 32'(C_NONE));
        ex_rd_addr = 5'd5; id_rs2_addr = 5'd5;
        ex_branch_taken = 1'b1;
        #1 check("branch_over_lu", 32'(ctrl), 32'(C_BR));
        ex_branch_taken = 1'b0;
        step();
        ex_mem_read = 1'b0;
        #1 check("lu_after", 32'(ctrl), 32'(C_NONE));
        clear_inputs();

        // Single-cycle memory access
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1 check("mem_1cyc", 32'(ctrl), 32'(C_NONE));
        step();
        check("mem_1cyc_cnt", 32'(dut.wait_cnt), 32'd0);

        // Memory wait: 3 stall cycles then ready
        dmem_ready = 1'b0;
        ex_mem_read = 1'b1; ex_rd_addr = 5'd4; id_rs1_addr = 5'd4; id_uses_rs1 = 1'b1;
        #1 check("mw_c1", 32'(ctrl), 32'(C_MW));
        step();
        check("mw_c2", 32'(ctrl), 32'(C_MW));
        check("mw_cnt1", 32'(dut.wait_cnt), 32'd1);
        step();
        check("mw_c3", 32'(ctrl), 32'(C_MW));
        check("mw_cnt2", 32'(dut.wait_cnt), 32'd2);
        dmem_ready = 1'b1;
        #1 check("mw_ready_lu", 32'(ctrl), 32'(C_LU));
        step();
        check("mw_state_run", 32'(dut.state), 32'd0);
        check("mw_cnt0", 32'(dut.wait_cnt), 32'd0);
        clear_inputs();

        // Branch held during a 2-cycle wait is applied on the ready cycle
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        #1 check("bw_c1", 32'(ctrl), 32'(C_MW));
        step();
        check("bw_c2", 32'(ctrl), 32'(C_MW));
        dmem_ready = 1'b1; dmem_req = 1'b0;
        #1 check("bw_ready", 32'(ctrl), 32'(C_BR));
        step();
        clear_inputs();
        #1 check("bw_after", 32'(ctrl), 32'(C_NONE));

        // Timeout: 16 wait cycles, then sticky ERROR
        dmem_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("to_wait%0d", i), 32'(ctrl), 32'(C_MW));
            check($sformatf("to_flag%0d", i), 32'(mem_timeout), 32'd0);
            step();
        end
        check("to_err_ctrl", 32'(ctrl), 32'(C_ER));
        check("to_err_flag", 32'(mem_timeout), 32'd1);
        dmem_ready = 1'b1; ex_branch_taken = 1'b1;
        step();
        check("to_sticky_ctrl", 32'(ctrl), 32'(C_ER));
        check("to_sticky_flag", 32'(mem_timeout), 32'd1);
        mem_rd_addr = 5'd6; mem_reg_write = 1'b1; ex_rs2_addr = 5'd6;
        #1 check("to_fwd_b", 32'(fwd_b_sel), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("to_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check("to_rst_flag", 32'(mem_timeout), 32'd0);
        check("to_rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_state", 32'(dut.state), 32'd0);

`ifdef HAZARD_PERF_EN
        rst_n = 1'b0;
        step();
        check("perf_rst", 32'(perf_load_use_cnt | perf_mem_stall_cnt | perf_flush_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd8; id_rs1_addr = 5'd8; id_uses_rs1 = 1'b1;
        step();
        ex_mem_read = 1'b0;
        step();
        ex_mem_read = 1'b1;
        step();
        ex_mem_read = 1'b0;
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        dmem_req = 1'b0; dmem_ready = 1'b1; ex_branch_taken = 1'b1;
        step();
        clear_inputs();
        step();
        check("perf_load_use", perf_load_use_cnt, 32'd2);
        check("perf_mem_stall", perf_mem_stall_cnt, 32'd4);
        check("perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
